dbus_uart: RTL and testbench

Memory-mapped 8N1 UART responder on the dcpu data bus: the responder end of the `o_cs`/`o_we`/`o_addr`/`o_dat`/`i_dat`/`i_ack` handshake the CPU initiates. It owns four registers: data, status, control and baud. It buffers traffic in TX and RX FIFOs, serialises and deserialises bytes, and raises an interrupt line suitable for the CPU `i_irq` input.

---
 rtl/dbus_uart_pkg.sv | 28 ++
 rtl/dbus_fifo.sv | 51 +++++
 rtl/dbus_uart.sv | 198 +++++++++++++++++++
 tb/tb_dbus_uart.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_uart_pkg.sv
// Shared constants for the dcpu data-bus UART: register offsets, STATUS bit
// positions, serial engine state encodings and the mid-bit sample helper.
package dbus_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_IDLE   = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;

    // Both engines walk the same four phases of an 8N1 frame.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Counter preload so the start bit is sampled (baud+1)/2 clocks after the edge.
    function automatic logic [15:0] half_baud(input logic [15:0] baud);
        if (baud == 16'd0) return 16'd0;
        return (baud >> 1) + {15'd0, baud[0]} - 16'd1;
    endfunction

endpackage

// File: rtl/dbus_fifo.sv
// Synchronous FIFO, 2^FD entries. Full/empty come from the pre-edge count, so a
// push into a full FIFO is dropped even when a pop happens in the same cycle.
module dbus_fifo #(
    parameter int W  = 8,
    parameter int FD = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 1 << FD;

    logic [W-1:0]  mem_q [DEPTH];
    logic [FD-1:0] wr_ptr_q, rd_ptr_q;
    logic [FD:0]   count_q;
    logic          do_push, do_pop;

    // The count never exceeds 2^FD, so its top bit alone means full.
    assign full_o  = count_q[FD];
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dbus_uart.sv
// Memory-mapped 8N1 UART responder for the dcpu data bus: DATA/STATUS/CTRL/BAUD
// registers, TX and RX FIFOs, serial engines and a level interrupt.
module dbus_uart
    import dbus_uart_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'hFF00,
    parameter int          FD       = 2,
    parameter logic [15:0] BAUD_RST = 16'd433
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    output logic        o_ack,
    output logic        o_irq,
    input  logic        i_rx,
    output logic        o_tx
);

    logic        ack_q, irq_q, tx_line_q, tx_line_d;
    logic [15:0] dat_q, rdata, status, baud_q;
    logic [1:0]  ctrl_q;
    logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic        sel, rd, wr, status_clr;
    logic        tx_push, tx_pop, tx_full, tx_empty, tx_idle;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_avail;
    logic [7:0]  tx_dout, rx_dout;
    logic        set_overrun, set_frame_err;

    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;

    // The ack cycle itself never starts a new request.
    assign sel        = i_cs & (i_addr[15:2] == BASE[15:2]) & ~ack_q;
    assign rd         = sel & ~i_we;
    assign wr         = sel & i_we;
    assign tx_push    = wr & (i_addr[1:0] == REG_DATA);
    assign rx_pop     = rd & (i_addr[1:0] == REG_DATA);
    assign status_clr = rd & (i_addr[1:0] == REG_STATUS);
    assign rx_avail   = ~rx_empty;
    assign tx_idle    = tx_empty & (tx_state_q == S_IDLE);

    assign o_dat = dat_q;
    assign o_ack = ack_q;
    assign o_irq = irq_q;
    assign o_tx  = tx_line_q;

    dbus_fifo #(.W(8), .FD(FD)) u_tx_fifo (
        .i_clk(i_clk), .i_reset(i_reset), .push_i(tx_push), .pop_i(tx_pop),
        .din_i(i_dat[7:0]), .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty)
    );

    dbus_fifo #(.W(8), .FD(FD)) u_rx_fifo (
        .i_clk(i_clk), .i_reset(i_reset), .push_i(rx_push), .pop_i(rx_pop),
        .din_i(rx_sh_q), .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        status               = '0;
        status[ST_RX_AVAIL]  = rx_avail;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_IDLE]   = tx_idle;
        status[ST_OVERRUN]   = overrun_q;
        status[ST_FRAME_ERR] = frame_err_q;
        case (i_addr[1:0])
            REG_DATA:   rdata = rx_empty ? 16'h0000 : {8'h00, rx_dout};
            REG_STATUS: rdata = status;
            REG_CTRL:   rdata = {14'd0, ctrl_q};
            default:    rdata = baud_q;
        endcase
        // A set in the same cycle as the clearing read wins.
        overrun_d   = set_overrun   | (overrun_q   & ~status_clr);
        frame_err_d = set_frame_err | (frame_err_q & ~status_clr);
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_sh_d    = tx_dout;
                tx_cnt_d   = baud_q;
                tx_state_d = S_START;
            end
            S_START: if (tx_cnt_q == 16'd0) begin
                tx_cnt_d   = baud_q;
                tx_bit_d   = 3'd0;
                tx_state_d = S_DATA;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            S_DATA: if (tx_cnt_q == 16'd0) begin
                tx_cnt_d = baud_q;
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            default: if (tx_cnt_q == 16'd0) tx_state_d = S_IDLE;
                     else tx_cnt_d = tx_cnt_q - 16'd1;
        endcase
        case (tx_state_q)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_sh_q[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_sh_d       = rx_sh_q;
        rx_push       = 1'b0;
        set_overrun   = 1'b0;
        set_frame_err = 1'b0;
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_cnt_d   = half_baud(baud_q);
                rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == 16'd0) begin
                rx_cnt_d   = baud_q;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
            S_DATA: if (rx_cnt_q == 16'd0) begin
                rx_cnt_d = baud_q;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
            default: if (rx_cnt_q == 16'd0) begin
                rx_push       = rx_s2_q;
                set_overrun   = rx_s2_q & rx_full;
                set_frame_err = ~rx_s2_q;
                rx_state_d    = S_IDLE;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
            ctrl_q      <= '0;
            baud_q      <= BAUD_RST;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_line_q   <= 1'b1;
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
        end else begin
            ack_q       <= sel;
            dat_q       <= rd ? rdata : 16'h0000;
            irq_q       <= (ctrl_q[0] & rx_avail) | (ctrl_q[1] & tx_idle);
            if (wr && i_addr[1:0] == REG_CTRL) ctrl_q <= i_dat[1:0];
            if (wr && i_addr[1:0] == REG_BAUD) baud_q <= i_dat;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_line_q   <= tx_line_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            rx_s1_q     <= i_rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
        end
    end

endmodule

// File: tb/tb_dbus_uart.sv
// Scoreboard bench for dbus_uart: bus reads queue their expected data, a monitor
// compares on every ack; serial traffic is decoded/driven at BAUD=3.
module tb_dbus_uart;
    import dbus_uart_pkg::*;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, we = 1'b0;
    logic [15:0] addr = '0, wdat = '0;
    logic [15:0] rdat;
    logic        ack, irq, tx, rx;
    logic        rx_drv = 1'b1, loop_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic        chk_q[$];
    string       name_q[$];

    assign rx = loop_en ? tx : rx_drv;

    dbus_uart #(.BASE(BASE), .FD(2), .BAUD_RST(16'd433)) dut (
        .i_clk(clk), .i_reset(rst), .i_cs(cs), .i_we(we), .i_addr(addr),
        .i_dat(wdat), .o_dat(rdat), .o_ack(ack), .o_irq(irq), .i_rx(rx), .o_tx(tx)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : mon
        logic [15:0] e;
        logic        c;
        string       nm;
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with no request outstanding, expected none");
            end else begin
                e  = exp_q.pop_front();
                c  = chk_q.pop_front();
                nm = name_q.pop_front();
                if (c) check(nm, {16'd0, rdat}, {16'd0, e});
            end
        end
    end

    // driver tasks
    task automatic bus(input logic w, input logic [1:0] off, input logic [15:0] d,
                       input logic [15:0] e, input string nm);
        logic got;
        @(negedge clk);
        cs   = 1'b1;
        we   = w;
        addr = BASE + {14'd0, off};
        wdat = d;
        exp_q.push_back(e);
        chk_q.push_back(!w);
        name_q.push_back(nm);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) got = 1'b1;
        end
        cs = 1'b0;
        we = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ack_timeout: got no ack, expected ack within 4 cycles", nm);
            void'(exp_q.pop_back());
            void'(chk_q.pop_back());
            void'(name_q.pop_back());
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (4) @(negedge clk);
        end
        rx_drv = stop;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_frame(input int to, output logic [7:0] b, output logic ok);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < to && !ok; i++) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1'b1;
        end
        if (ok) begin
            repeat (2) @(negedge clk);
            if (tx !== 1'b0) ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat (4) @(negedge clk);
                b[k] = tx;
            end
            repeat (4) @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
    endtask

    initial begin
        logic [9:0] fr;
        logic [3:0] seen;
        logic [7:0] b, eb;
        logic       ok, found, hit;
        int         ones;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_ack", ack, 0);
        check("reset_irq", irq, 0);
        rst = 1'b0;
        bus(0, REG_STATUS, 0, 16'h0004, "reset_status");
        bus(0, REG_BAUD, 0, 16'd433, "reset_baud");
        bus(0, REG_CTRL, 0, 16'h0000, "reset_ctrl");

        // single TX frame, checked cycle by cycle
        bus(1, REG_BAUD, 16'd3, 0, "wr_baud");
        bus(0, REG_BAUD, 0, 16'd3, "rd_baud");
        bus(1, REG_DATA, 16'h0055, 0, "wr_tx55");
        ones  = 0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
            else ones++;
        end
        check("tx_start_latency", ones, 2);
        fr = {1'b1, 8'h55, 1'b0};
        for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < 4; c++) begin
                if (bi != 0 || c != 0) @(negedge clk);
                seen[c] = tx;
            end
            check($sformatf("tx55_bit%0d", bi), seen, {4{fr[bi]}});
        end
        bus(0, REG_STATUS, 0, 16'h0004, "tx_done_status");

        // loopback
        loop_en = 1'b1;
        bus(1, REG_DATA, 16'h00A5, 0, "wr_txA5");
        repeat (60) @(negedge clk);
        bus(0, REG_STATUS, 0, 16'h0005, "loop_status");
        bus(0, REG_DATA, 0, 16'h00A5, "loop_data");
        bus(0, REG_STATUS, 0, 16'h0004, "loop_status_after");
        loop_en = 1'b0;

        // TX overflow: 7 writes, only 5 frames leave
        fork
            begin
                for (int i = 1; i <= 7; i++) bus(1, REG_DATA, 16'(i * 16'h0011), 0, "wr_burst");
                bus(0, REG_STATUS, 0, 16'h0002, "tx_full_status");
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    tx_frame(100, b, ok);
                    eb = 8'((f + 1) * 8'h11);
                    check($sformatf("tx_frame%0d_ok", f), ok, 1);
                    check($sformatf("tx_frame%0d_byte", f), b, eb);
                end
                tx_frame(80, b, ok);
                check("tx_no_6th_frame", ok, 0);
            end
        join

        // RX overrun and interrupt
        bus(1, REG_CTRL, 16'h0001, 0, "wr_ctrl");
        bus(0, REG_CTRL, 0, 16'h0001, "rd_ctrl");
        for (int i = 0; i < 5; i++) send_frame(8'h31 + 8'(i), 1'b1);
        repeat (4) @(negedge clk);
        check("irq_rx", irq, 1);
        bus(1, REG_DATA, 16'h0000, 0, "wr_tx_busy");
        bus(0, REG_STATUS, 0, 16'h0009, "overrun_status");
        bus(0, REG_STATUS, 0, 16'h0001, "overrun_cleared");
        for (int i = 0; i < 4; i++) bus(0, REG_DATA, 0, 16'h0031 + 16'(i), "rx_byte");
        bus(0, REG_DATA, 0, 16'h0000, "rx_empty_read");
        repeat (3) @(negedge clk);
        check("irq_cleared", irq, 0);

        // held chip select: STATUS then DATA
        repeat (50) @(negedge clk);
        @(negedge clk);
        cs   = 1'b1;
        we   = 1'b0;
        addr = BASE + 16'd1;
        exp_q.push_back(16'h0004); chk_q.push_back(1'b1); name_q.push_back("hs_status");
        exp_q.push_back(16'h0000); chk_q.push_back(1'b1); name_q.push_back("hs_data");
        @(posedge clk);
        #1;
        addr = BASE;
        @(negedge clk);
        check("hs_ack_first", ack, 1);
        @(negedge clk);
        check("hs_ack_gap", ack, 0);
        @(negedge clk);
        check("hs_ack_second", ack, 1);
        cs = 1'b0;

        // unselected address
        @(negedge clk);
        cs   = 1'b1;
        addr = BASE + 16'd4;
        hit  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack === 1'b1) hit = 1'b1;
        end
        cs = 1'b0;
        check("no_ack_base4", hit, 0);

        // framing error
        send_frame(8'h5A, 1'b0);
        repeat (4) @(negedge clk);
        bus(0, REG_STATUS, 0, 16'h0014, "frame_err_status");
        bus(0, REG_DATA, 0, 16'h0000, "frame_err_no_byte");
        bus(0, REG_STATUS, 0, 16'h0004, "frame_err_cleared");

        // final report
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
